imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning consecutive contested cycles the fetch port may lose before it is forced a grant (range 1-15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports if_req input 1, if_addr input 32  fetch read request and byte address.
REQ-005 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output 32, if_err output 1  fetch grant, response valid, instruction word, misaligned flag.
REQ-006 SHALL have ports dbg_req input 1, dbg_we input 1, dbg_addr input 32, dbg_wdata input 32  debug/loader read or write request.
REQ-007 SHALL have ports dbg_gnt output 1, dbg_rvalid output 1, dbg_rdata output 32  debug grant, response/ack, read data.
REQ-008 SHALL have ports dbg_lock input 1, lock_active output 1  exclusive loader ownership request and its status.
REQ-009 SHALL have ports if_flush input 1  discard fetch response due next cycle.
REQ-010 SHALL have memory-side ports mem_addr output 32, mem_read_en output 1, mem_we output 1, mem_wdata output 32, mem_rdata input 32 (combinational read data).

Function
REQ-011 SHALL grant at most one requester per cycle; if_gnt and dbg_gnt are combinational and never both high.
REQ-012 SHALL drive mem_addr/mem_read_en/mem_we/mem_wdata combinationally from the granted requester in the grant cycle; with no grant mem_read_en=0, mem_we=0, mem_addr=0.
REQ-013 SHALL register response: grant in cycle N -> rvalid high for exactly cycle N+1 with rdata = mem_rdata sampled at end of cycle N; one access per cycle, fully pipelined.
REQ-014 SHALL pulse dbg_rvalid for writes as acknowledge, with dbg_rdata = 0 and mem_we high only in grant cycle.
REQ-015 SHALL, when if_addr[1:0] != 0 and granted, suppress mem_read_en, return if_rdata = 32'h00000013 (NOP) and if_err=1 with if_rvalid in N+1; dbg_addr[1:0] is ignored (word aligned).
REQ-016 SHALL, when contested (if_req and dbg_req, no lock), grant dbg, except grant IF when wait counter equals MAX_WAIT.
REQ-017 SHALL increment 4-bit wait counter on each cycle IF loses a contest, clear it on any IF grant or when if_req is low.
REQ-018 SHALL use states IDLE, RESP_IF, RESP_DBG, LOCKED: next state RESP_IF/RESP_DBG after respective grant, IDLE with no grant, LOCKED while dbg_lock high regardless of prior state.
REQ-019 SHALL, in LOCKED, never grant IF, grant dbg on every dbg_req, assert lock_active, and drive if_rdata = NOP; leaving LOCKED (dbg_lock low) takes effect same cycle for arbitration, lock_active drops next cycle.
REQ-020 SHALL, on dbg_lock rising while an IF response is due, still deliver that response in N+1.
REQ-021 SHALL, on if_flush high in cycle N+1, force if_rvalid=0 and if_err=0 that cycle; a new IF grant in the same cycle as if_flush is permitted and its response is not flushed.
REQ-022 SHALL hold if_rdata = NOP and dbg_rdata = 0 whenever the corresponding rvalid is low.

Reset
REQ-023 SHALL, while reset high, drive if_gnt=0, dbg_gnt=0, mem_read_en=0, mem_we=0, if_rvalid=0, dbg_rvalid=0, if_err=0, lock_active=0, if_rdata=NOP, dbg_rdata=0.
REQ-024 SHALL on reset clear state to IDLE, wait counter and RR pointer to 0, and drop any in-flight response (no rvalid in the cycle after reset deasserts).

Configuration
REQ-025 SHALL support macro IMEM_ARB_ROUND_ROBIN_EN: when defined, contested cycles alternate winners via 1-bit last-winner pointer (reset to IF-last, so dbg wins first contest) and the wait counter/MAX_WAIT logic is omitted; when undefined, REQ-016/017 fixed-priority-with-starvation behaviour applies.

Verification
REQ-026 SHALL cover: if_req, if_addr=0x8, mem word 0x00500093 -> if_gnt in N, if_rvalid with if_rdata=0x00500093 in N+1.
REQ-027 SHALL cover: if_req and dbg_req held high 10 cycles, MAX_WAIT=4, macro undefined -> grants dbg x4, IF x1, repeating; with macro defined -> strictly alternating dbg, IF.
REQ-028 SHALL cover: dbg_lock high, dbg writes 0xDEADBEEF to 0x10, if_req high -> if_gnt 0 throughout, lock_active 1, mem_we pulse, dbg_rvalid ack; after unlock IF read of 0x10 returns 0xDEADBEEF.
REQ-029 SHALL cover: IF grant at 0x4 in N, if_flush in N+1 -> if_rvalid 0 in N+1; IF access at 0x6 -> if_err 1, if_rdata 0x00000013, mem_read_en 0.
REQ-030 SHALL cover: reset asserted in cycle after grant -> no rvalid, all outputs at REQ-023 values, first post-reset contest resolved per configuration.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between fetch (IF) and a debug/loader port; responses 1 cycle after grant.
// Contests go to debug with an IF starvation guard (MAX_WAIT), or alternate when IMEM_ARB_ROUND_ROBIN_EN is defined.
module imem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        if_flush,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    input  logic        dbg_lock,
    output logic        lock_active,
    output logic [31:0] mem_addr,
    output logic        mem_read_en,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DBG, LOCKED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_if_gnt;
    logic        w_dbg_gnt;
    logic        w_contest;
    logic        w_if_misal;
    logic        w_if_wins;
    logic        r_if_vld;
    logic        r_if_err;
    logic [31:0] r_if_rdata;
    logic        r_dbg_vld;
    logic [31:0] r_dbg_rdata;
    logic        w_unused_dbg_lsb;

    assign w_contest        = if_req & dbg_req & ~dbg_lock;
    assign w_if_misal       = |if_addr[1:0];
    assign w_unused_dbg_lsb = ^dbg_addr[1:0];

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic r_last_dbg;

    // Reset value "IF won last" hands the first contest to debug.
    assign w_if_wins = r_last_dbg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dbg <= 1'b0;
        end else if (w_if_gnt) begin
            r_last_dbg <= 1'b0;
        end else if (w_dbg_gnt) begin
            r_last_dbg <= 1'b1;
        end
    end
`else
    logic [3:0] r_wait;

    assign w_if_wins = (r_wait == 4'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= 4'd0;
        end else if (!if_req || w_if_gnt) begin
            r_wait <= 4'd0;
        end else if (w_contest) begin
            r_wait <= r_wait + 4'd1;
        end
    end
`endif

    // Lock is taken from the live input so releasing it re-opens IF arbitration immediately.
    always_comb begin
        w_if_gnt  = 1'b0;
        w_dbg_gnt = 1'b0;
        if (!reset) begin
            if (dbg_lock) begin
                w_dbg_gnt = dbg_req;
            end else if (w_contest) begin
                w_if_gnt  = w_if_wins;
                w_dbg_gnt = ~w_if_wins;
            end else begin
                w_if_gnt  = if_req;
                w_dbg_gnt = dbg_req;
            end
        end
    end

    always_comb begin
        mem_addr    = 32'd0;
        mem_read_en = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 32'd0;
        if (w_if_gnt) begin
            mem_addr    = if_addr;
            mem_read_en = ~w_if_misal;
        end else if (w_dbg_gnt) begin
            mem_addr    = {dbg_addr[31:2], 2'b00};
            mem_read_en = ~dbg_we;
            mem_we      = dbg_we;
            mem_wdata   = dbg_wdata;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (dbg_lock) begin
            w_state_nxt = LOCKED;
        end else if (w_if_gnt) begin
            w_state_nxt = RESP_IF;
        end else if (w_dbg_gnt) begin
            w_state_nxt = RESP_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response pipeline runs independently of the FSM so an IF response survives a lock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_vld    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= NOP;
            r_dbg_vld   <= 1'b0;
            r_dbg_rdata <= 32'd0;
        end else begin
            r_if_vld    <= w_if_gnt;
            r_if_err    <= w_if_gnt & w_if_misal;
            r_if_rdata  <= w_if_misal ? NOP : mem_rdata;
            r_dbg_vld   <= w_dbg_gnt;
            r_dbg_rdata <= dbg_we ? 32'd0 : mem_rdata;
        end
    end

    assign if_gnt      = w_if_gnt;
    assign dbg_gnt     = w_dbg_gnt;
    assign if_rvalid   = r_if_vld & ~if_flush & ~reset;
    assign if_err      = if_rvalid & r_if_err;
    assign if_rdata    = if_rvalid ? r_if_rdata : NOP;
    assign dbg_rvalid  = r_dbg_vld & ~reset;
    assign dbg_rdata   = dbg_rvalid ? r_dbg_rdata : 32'd0;
    assign lock_active = (r_state == LOCKED) & ~reset;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a behavioural model predicts grants and queues responses checked by a monitor.
module tb_imem_arbiter;

    localparam int          MAXW = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        if_flush = 1'b0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [31:0] dbg_addr = 32'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_lock = 1'b0;
    logic        lock_active;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read_en, mem_we;

    imem_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err), .if_flush(if_flush),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock), .lock_active(lock_active),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h0050_0093 : (32'hA500_0000 ^ (i * 32'h0001_0203));
    endfunction

    // Memory seen by the DUT: combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t        if_q[$];
    rsp_t        dbg_q[$];
    logic [31:0] ref_mem [0:63];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          if_losses = 0;
    bit          last_was_dbg = 1'b0;
    bit          prev_lock = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict grants and memory-side outputs, queue responses.
    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic lk, input logic fl);
        logic        e_if, e_dbg, misal, contest;
        logic [31:0] e_addr;
        int          idx;
        @(negedge clk);
        cyc++;
        reset = rst; if_req = ir; if_addr = ia; dbg_req = dr; dbg_we = dw;
        dbg_addr = da; dbg_wdata = dd; dbg_lock = lk; if_flush = fl;
        if (rst) begin
            if_q.delete();
            dbg_q.delete();
        end
        #1;
        e_if = 1'b0; e_dbg = 1'b0;
        misal = (ia[1:0] != 2'b00);
        contest = ir && dr && !lk;
        if (!rst) begin
            if (lk) e_dbg = dr;
            else if (contest) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
                e_if = last_was_dbg;
`else
                e_if = (if_losses >= MAXW);
`endif
                e_dbg = !e_if;
            end else begin
                e_if = ir; e_dbg = dr;
            end
        end
        e_addr = e_if ? ia : (e_dbg ? {da[31:2], 2'b00} : 32'd0);
        chk("if_gnt", if_gnt, e_if);
        chk("dbg_gnt", dbg_gnt, e_dbg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_read_en", mem_read_en, (e_if && !misal) || (e_dbg && !dw));
        chk("mem_we", mem_we, e_dbg && dw);
        if (e_dbg && dw) chk("mem_wdata", mem_wdata, dd);
        chk("lock_active", lock_active, !rst && prev_lock);
        if (e_if) begin
            idx = int'(ia[7:2]);
            if_q.push_back('{due: cyc + 1, d: misal ? NOP : ref_mem[idx], e: misal});
        end
        if (e_dbg) begin
            idx = int'(da[7:2]);
            dbg_q.push_back('{due: cyc + 1, d: dw ? 32'd0 : ref_mem[idx], e: 1'b0});
            if (dw) ref_mem[idx] = dd;
        end
        if (rst) begin
            if_losses = 0; last_was_dbg = 1'b0; prev_lock = 1'b0;
        end else begin
            if (!ir || e_if) if_losses = 0;
            else if (contest) if_losses++;
            if (e_if) last_was_dbg = 1'b0;
            else if (e_dbg) last_was_dbg = 1'b1;
            prev_lock = lk;
        end
    endtask

    // Monitor: compares response outputs against the queued expectations each cycle.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (if_q.size() > 0 && if_q[0].due == cyc) begin
                r = if_q.pop_front();
                if (if_flush) begin
                    chk("if_rvalid_flush", if_rvalid, 1'b0);
                    chk("if_rdata_flush", if_rdata, NOP);
                    chk("if_err_flush", if_err, 1'b0);
                end else begin
                    chk("if_rvalid", if_rvalid, 1'b1);
                    chk("if_rdata", if_rdata, r.d);
                    chk("if_err", if_err, r.e);
                end
            end else begin
                chk("if_rvalid_idle", if_rvalid, 1'b0);
                chk("if_rdata_idle", if_rdata, NOP);
                chk("if_err_idle", if_err, 1'b0);
            end
            if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
                r = dbg_q.pop_front();
                chk("dbg_rvalid", dbg_rvalid, 1'b1);
                chk("dbg_rdata", dbg_rdata, r.d);
            end else begin
                chk("dbg_rvalid_idle", dbg_rvalid, 1'b0);
                chk("dbg_rdata_idle", dbg_rdata, 32'd0);
            end
        end
    end

    initial begin
        logic [9:0]  pat;
        logic [9:0]  pat_exp;
        logic        lk, rst, ir, dr, dw, fl;
        logic [31:0] ia, da, dd;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        pat_exp = 10'b10_1010_1010;
`else
        pat_exp = 10'b10_0001_0000;
`endif
        repeat (3) step(1, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);
        chk("reset_if_gnt", if_gnt, 1'b0);

        // Plain fetch of a known instruction word.
        step(0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Sustained contention pattern.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h0, 1, 0, 32'h20, 32'h0, 0, 0);
            pat[i] = if_gnt;
        end
        chk("contest_pattern", {22'd0, pat}, {22'd0, pat_exp});
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Locked loader write, then fetch of the written word after unlock.
        step(0, 1, 32'h10, 1, 1, 32'h10, 32'hDEAD_BEEF, 1, 0);
        step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("unlock_fetch", if_rdata, 32'hDEAD_BEEF);

        // Lock rising while an IF response is outstanding.
        step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Flush with a fresh grant in the same cycle, then a misaligned fetch.
        step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 32'hC, 0, 0, 32'h0, 32'h0, 0, 1);
        step(0, 1, 32'h6, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Reset right after a grant, then the first contest afterwards.
        step(0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 32'h8, 1, 0, 32'h24, 32'h0, 0, 0);
        step(0, 1, 32'h8, 1, 0, 32'h24, 32'h0, 0, 0);
        chk("post_reset_contest", dbg_gnt, 1'b1);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        lk = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) lk = ~lk;
            rst = ($urandom_range(0, 99) == 0);
            ir  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 2) != 0);
            dw  = $urandom_range(0, 1) != 0;
            fl  = ($urandom_range(0, 4) == 0);
            ia  = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 3) == 0) ia = ia | 32'($urandom_range(1, 3));
            da  = 32'($urandom_range(0, 255));
            dd  = $urandom;
            step(rst, ir, ia, dr, dw, da, dd, lk, fl);
        end
        repeat (3) step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("drain_if_q", 32'(if_q.size()), 32'd0);
        chk("drain_dbg_q", 32'(dbg_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
